// File: rtl/axis_write_arbiter_if.sv
// One AXI-Stream write channel (data, byte strobes, valid/last, ready).
// The master drives the payload toward the slave; the slave returns tready.
interface axis_write_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   wr_tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output wr_tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input wr_tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_write_arbiter.sv
// Two-requester, packet-granular round-robin arbiter onto one AXI-Stream write port.
// A grant is released on tlast, or forced after MAX_BEATS beats with trunc_err raised.
module axis_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                 axis_aclk,
  input  logic                 axis_areset,
  axis_write_arbiter_if.slave  s01_axis,
  axis_write_arbiter_if.slave  s02_axis,
  axis_write_arbiter_if.master m01_axis,
  output logic                 grant_id,
  output logic                 busy,
  output logic [15:0]          s01_pkt_cnt,
  output logic [15:0]          s02_pkt_cnt,
  output logic                 trunc_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_S01 = 2'd1;
  localparam logic [1:0] GNT_S02 = 2'd2;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_s02_q, prio_s02_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic [15:0] cnt2_q, cnt2_d;
  logic        trunc_q, trunc_d;

  logic gnt_valid;
  logic gnt_last;
  logic at_limit;
  logic accept;
  logic pkt_end;

  assign at_limit = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    m01_axis.wr_tdata = {DATA_WIDTH{1'b0}};
    m01_axis.tstrb    = {(DATA_WIDTH/8){1'b0}};
    m01_axis.tvalid   = 1'b0;
    m01_axis.tlast    = 1'b0;
    s01_axis.tready   = 1'b0;
    s02_axis.tready   = 1'b0;
    gnt_valid         = 1'b0;
    gnt_last          = 1'b0;
    case (state_q)
      GNT_S01: begin
        m01_axis.wr_tdata = s01_axis.wr_tdata;
        m01_axis.tstrb    = s01_axis.tstrb;
        m01_axis.tvalid   = s01_axis.tvalid;
        m01_axis.tlast    = s01_axis.tlast | at_limit;
        s01_axis.tready   = m01_axis.tready;
        gnt_valid         = s01_axis.tvalid;
        gnt_last          = s01_axis.tlast;
      end
      GNT_S02: begin
        m01_axis.wr_tdata = s02_axis.wr_tdata;
        m01_axis.tstrb    = s02_axis.tstrb;
        m01_axis.tvalid   = s02_axis.tvalid;
        m01_axis.tlast    = s02_axis.tlast | at_limit;
        s02_axis.tready   = m01_axis.tready;
        gnt_valid         = s02_axis.tvalid;
        gnt_last          = s02_axis.tlast;
      end
      default: ;
    endcase
  end

  assign accept  = gnt_valid & m01_axis.tready;
  assign pkt_end = accept & (gnt_last | at_limit);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_s02_d = prio_s02_q;
    beat_cnt_d = beat_cnt_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    trunc_d    = trunc_q;
    case (state_q)
      GNT_S01, GNT_S02: begin
        if (pkt_end) begin
          state_d    = IDLE;
          beat_cnt_d = 16'd0;
          prio_s02_d = (state_q == GNT_S01);
          if (state_q == GNT_S01) cnt1_d = cnt1_q + 16'd1;
          else                    cnt2_d = cnt2_q + 16'd1;
          if (!gnt_last) trunc_d = 1'b1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
        end
      end
      default: begin
        // Illegal encodings fall back to arbitration just like IDLE.
        state_d    = IDLE;
        beat_cnt_d = 16'd0;
        if (s01_axis.tvalid && (!s02_axis.tvalid || !prio_s02_q)) begin
          state_d = GNT_S01;
          grant_d = 1'b0;
        end else if (s02_axis.tvalid) begin
          state_d = GNT_S02;
          grant_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      prio_s02_q <= 1'b0;
      beat_cnt_q <= 16'd0;
      cnt1_q     <= 16'd0;
      cnt2_q     <= 16'd0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_s02_q <= prio_s02_d;
      beat_cnt_q <= beat_cnt_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign s01_pkt_cnt = cnt1_q;
  assign s02_pkt_cnt = cnt2_q;
  assign trunc_err   = trunc_q;

endmodule

// File: tb/tb_axis_write_arbiter.sv
// Directed vector table for the write arbiter, plus hand-written reset and
// round-robin streaming sequences. MAX_BEATS is 4 so truncation is reachable.
module tb_axis_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        grant_id, busy, trunc_err;
  logic [15:0] s01_pkt_cnt, s02_pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_write_arbiter_if #(.DATA_WIDTH(32)) s01_if ();
  axis_write_arbiter_if #(.DATA_WIDTH(32)) s02_if ();
  axis_write_arbiter_if #(.DATA_WIDTH(32)) m01_if ();

  axis_write_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4)) dut (
    .axis_aclk   (clk),
    .axis_areset (rst),
    .s01_axis    (s01_if),
    .s02_axis    (s02_if),
    .m01_axis    (m01_if),
    .grant_id    (grant_id),
    .busy        (busy),
    .s01_pkt_cnt (s01_pkt_cnt),
    .s02_pkt_cnt (s02_pkt_cnt),
    .trunc_err   (trunc_err)
  );

  typedef struct {
    bit          pre_rst;
    bit          rst;
    logic        s1v, s1l;
    logic [31:0] s1d;
    logic        s2v, s2l;
    logic [31:0] s2d;
    logic        mr;
    logic        mv, ml;
    logic [31:0] md;
    logic        s1r, s2r, bsy, gid;
    logic [15:0] c1, c2;
    logic        tr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit pre, input bit r,
                              input logic s1v, input logic s1l, input logic [31:0] s1d,
                              input logic s2v, input logic s2l, input logic [31:0] s2d,
                              input logic mr,
                              input logic mv, input logic ml, input logic [31:0] md,
                              input logic s1r, input logic s2r, input logic bsy, input logic gid,
                              input logic [15:0] c1, input logic [15:0] c2, input logic tr);
    vec_t v;
    v.pre_rst = pre; v.rst = r;
    v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
    v.s2v = s2v; v.s2l = s2l; v.s2d = s2d;
    v.mr = mr; v.mv = mv; v.ml = ml; v.md = md;
    v.s1r = s1r; v.s2r = s2r; v.bsy = bsy; v.gid = gid;
    v.c1 = c1; v.c2 = c2; v.tr = tr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=0x%0h required=0x%0h", name, vi, act, exp);
    end
  endtask

  task automatic drive(input logic s1v, input logic s1l, input logic [31:0] s1d,
                       input logic s2v, input logic s2l, input logic [31:0] s2d, input logic mr);
    s01_if.tvalid = s1v; s01_if.tlast = s1l; s01_if.wr_tdata = s1d; s01_if.tstrb = 4'hF;
    s02_if.tvalid = s2v; s02_if.tlast = s2l; s02_if.wr_tdata = s2d; s02_if.tstrb = 4'h3;
    m01_if.tready = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int idx1, idx2, pkts, cyc;
    bit acc1, acc2, bubble;
    logic [3:0] exp_strb;

    // Reset held two cycles while s01 is requesting.
    rst = 1'b1;
    drive(1, 0, 32'h55, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s1r",  -1, 32'(s01_if.tready), 0);
    chk("rst_s2r",  -1, 32'(s02_if.tready), 0);
    chk("rst_mv",   -1, 32'(m01_if.tvalid), 0);
    chk("rst_busy", -1, 32'(busy), 0);
    chk("rst_c1",   -1, 32'(s01_pkt_cnt), 0);
    chk("rst_c2",   -1, 32'(s02_pkt_cnt), 0);
    chk("rst_tr",   -1, 32'(trunc_err), 0);
    chk("rst_gid",  -1, 32'(grant_id), 0);
    $display("reset check done busy=%0d mv=%0d", busy, m01_if.tvalid);

    // pre rst | s1 v l d | s2 v l d | mr | exp mv ml md | s1r s2r busy gid | c1 c2 tr
    // Three-beat s01 packet, then ties resolved round-robin, stall with tready low.
    add(1,0, 1,0,'h55, 0,0,'h0,  1, 0,0,'h0,  0,0,0,0, 0,0,0);
    add(0,0, 1,0,'h55, 0,0,'h0,  1, 1,0,'h55, 1,0,1,0, 0,0,0);
    add(0,0, 1,0,'h22, 0,0,'h0,  1, 1,0,'h22, 1,0,1,0, 0,0,0);
    add(0,0, 1,1,'h24, 0,0,'h0,  1, 1,1,'h24, 1,0,1,0, 0,0,0);
    add(0,0, 0,0,'h0,  0,0,'h0,  1, 0,0,'h0,  0,0,0,0, 1,0,0);
    add(0,0, 1,0,'hA1, 1,0,'hB1, 1, 0,0,'h0,  0,0,0,0, 1,0,0);
    add(0,0, 1,0,'hA1, 1,0,'hB1, 1, 1,0,'hB1, 0,1,1,1, 1,0,0);
    add(0,0, 1,0,'hA1, 1,1,'hB2, 1, 1,1,'hB2, 0,1,1,1, 1,0,0);
    add(0,0, 1,1,'hA1, 1,0,'hB3, 1, 0,0,'h0,  0,0,0,1, 1,1,0);
    add(0,0, 1,1,'hA1, 1,0,'hB3, 0, 1,1,'hA1, 0,0,1,0, 1,1,0);
    add(0,0, 1,1,'hA1, 1,0,'hB3, 1, 1,1,'hA1, 1,0,1,0, 1,1,0);
    add(0,0, 0,0,'h0,  0,0,'h0,  1, 0,0,'h0,  0,0,0,0, 2,1,0);
    // Five-cycle backpressure mid s01 packet while s02 waits.
    add(1,0, 1,0,'hC0, 1,1,'hE0, 1, 0,0,'h0,  0,0,0,0, 0,0,0);
    add(0,0, 1,0,'hC0, 1,1,'hE0, 1, 1,0,'hC0, 1,0,1,0, 0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,0, 1,0,'hC1, 1,1,'hE0, 0, 1,0,'hC1, 0,0,1,0, 0,0,0);
    add(0,0, 1,0,'hC1, 1,1,'hE0, 1, 1,0,'hC1, 1,0,1,0, 0,0,0);
    add(0,0, 1,1,'hC2, 1,1,'hE0, 1, 1,1,'hC2, 1,0,1,0, 0,0,0);
    add(0,0, 0,0,'h0,  1,1,'hE0, 1, 0,0,'h0,  0,0,0,0, 1,0,0);
    add(0,0, 0,0,'h0,  1,1,'hE0, 1, 1,1,'hE0, 0,1,1,1, 1,0,0);
    // Six-beat s02 packet truncated at beat 4, remainder sent as a new packet.
    add(1,0, 0,0,'h0,  1,0,'hF0, 1, 0,0,'h0,  0,0,0,0, 0,0,0);
    add(0,0, 0,0,'h0,  1,0,'hF0, 1, 1,0,'hF0, 0,1,1,1, 0,0,0);
    add(0,0, 0,0,'h0,  1,0,'hF1, 1, 1,0,'hF1, 0,1,1,1, 0,0,0);
    add(0,0, 0,0,'h0,  1,0,'hF2, 1, 1,0,'hF2, 0,1,1,1, 0,0,0);
    add(0,0, 0,0,'h0,  1,0,'hF3, 1, 1,1,'hF3, 0,1,1,1, 0,0,0);
    add(0,0, 0,0,'h0,  1,0,'hF4, 1, 0,0,'h0,  0,0,0,1, 0,1,1);
    add(0,0, 0,0,'h0,  1,0,'hF4, 1, 1,0,'hF4, 0,1,1,1, 0,1,1);
    add(0,0, 0,0,'h0,  1,1,'hF5, 1, 1,1,'hF5, 0,1,1,1, 0,1,1);
    add(0,0, 0,0,'h0,  0,0,'h0,  1, 0,0,'h0,  0,0,0,1, 0,2,1);
    // Reset during beat 2 of an s01 packet, then a clean 4-beat packet and s02.
    add(0,0, 1,0,'h60, 0,0,'h0,  1, 0,0,'h0,  0,0,0,1, 0,2,1);
    add(0,0, 1,0,'h60, 0,0,'h0,  1, 1,0,'h60, 1,0,1,0, 0,2,1);
    add(0,1, 1,0,'h61, 0,0,'h0,  1, 1,0,'h61, 1,0,1,0, 0,2,1);
    add(0,0, 1,0,'h61, 1,0,'h70, 1, 0,0,'h0,  0,0,0,0, 0,0,0);
    add(0,0, 1,0,'h80, 1,0,'h70, 1, 1,0,'h80, 1,0,1,0, 0,0,0);
    add(0,0, 1,0,'h81, 1,0,'h70, 1, 1,0,'h81, 1,0,1,0, 0,0,0);
    add(0,0, 1,0,'h82, 1,0,'h70, 1, 1,0,'h82, 1,0,1,0, 0,0,0);
    add(0,0, 1,1,'h83, 1,0,'h70, 1, 1,1,'h83, 1,0,1,0, 0,0,0);
    add(0,0, 0,0,'h0,  1,1,'h70, 1, 0,0,'h0,  0,0,0,0, 1,0,0);
    add(0,0, 0,0,'h0,  1,1,'h70, 1, 1,1,'h70, 0,1,1,1, 1,0,0);
    add(0,0, 0,0,'h0,  0,0,'h0,  1, 0,0,'h0,  0,0,0,1, 1,1,0);

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset();
      rst = vecs[i].rst;
      drive(vecs[i].s1v, vecs[i].s1l, vecs[i].s1d, vecs[i].s2v, vecs[i].s2l, vecs[i].s2d, vecs[i].mr);
      @(negedge clk);
      exp_strb = !vecs[i].bsy ? 4'h0 : (vecs[i].gid ? 4'h3 : 4'hF);
      chk("m_tvalid", i, 32'(m01_if.tvalid),  32'(vecs[i].mv));
      chk("m_tlast",  i, 32'(m01_if.tlast),   32'(vecs[i].ml));
      chk("m_tdata",  i, m01_if.wr_tdata,     vecs[i].md);
      chk("m_tstrb",  i, 32'(m01_if.tstrb),   32'(exp_strb));
      chk("s1_ready", i, 32'(s01_if.tready),  32'(vecs[i].s1r));
      chk("s2_ready", i, 32'(s02_if.tready),  32'(vecs[i].s2r));
      chk("busy",     i, 32'(busy),           32'(vecs[i].bsy));
      chk("grant_id", i, 32'(grant_id),       32'(vecs[i].gid));
      chk("s01_cnt",  i, 32'(s01_pkt_cnt),    32'(vecs[i].c1));
      chk("s02_cnt",  i, 32'(s02_pkt_cnt),    32'(vecs[i].c2));
      chk("trunc",    i, 32'(trunc_err),      32'(vecs[i].tr));
      $display("vec %0d rst=%0d mv=%0d ml=%0d md=%h gid=%0d busy=%0d", i, rst,
               m01_if.tvalid, m01_if.tlast, m01_if.wr_tdata, grant_id, busy);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Both requesters stream 2-beat packets back to back: grants must alternate.
    do_reset();
    idx1 = 0; idx2 = 0; pkts = 0; cyc = 0; bubble = 0;
    while (pkts < 4 && cyc < 40) begin
      drive(1, idx1[0], 32'h1000 + 32'(idx1), 1, idx2[0], 32'h2000 + 32'(idx2), 1);
      @(negedge clk);
      if (bubble) begin
        chk("rr_bubble", pkts, 32'(m01_if.tvalid), 0);
        bubble = 0;
      end
      acc1 = s01_if.tvalid & s01_if.tready;
      acc2 = s02_if.tvalid & s02_if.tready;
      if (m01_if.tvalid && m01_if.tready) begin
        chk("rr_data", pkts, m01_if.wr_tdata,
            grant_id ? 32'h2000 + 32'(idx2) : 32'h1000 + 32'(idx1));
        if (m01_if.tlast) begin
          chk("rr_gid", pkts, 32'(grant_id), 32'(pkts % 2));
          $display("rr packet %0d granted to %0d", pkts, grant_id);
          pkts++;
          bubble = 1;
        end
      end
      @(posedge clk);
      #1;
      if (acc1) idx1++;
      if (acc2) idx2++;
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rr_pkts", 0, 32'(pkts), 4);
    @(negedge clk);
    chk("rr_c1", 0, 32'(s01_pkt_cnt), 2);
    chk("rr_c2", 0, 32'(s02_pkt_cnt), 2);
    chk("rr_tr", 0, 32'(trunc_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_write_arbiter.md
AXIS_WRITE_ARBITER -- requirements
Module: axis_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, tdata width; tstrb width is DATA_WIDTH/8.
REQ-002 Parameter MAX_BEATS, default 256, maximum beats per granted packet before forced release; legal range 2..65535.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 axis_aclk  in  1  sole clock; all state changes on rising edge.
REQ-005 axis_areset  in  1  synchronous active-high reset.
REQ-006 s01_axis_wr_tdata  in  DATA_WIDTH  requester 1 write data.
REQ-007 s01_axis_tstrb  in  DATA_WIDTH/8  requester 1 byte strobes.
REQ-008 s01_axis_tvalid / s01_axis_tlast  in  1 each  requester 1 beat valid / last beat of packet.
REQ-009 s01_axis_tready  out  1  requester 1 beat accepted.
REQ-010 s02_axis_wr_tdata, s02_axis_tstrb, s02_axis_tvalid, s02_axis_tlast, s02_axis_tready: same widths and directions as s01, requester 2.
REQ-011 m01_axis_wr_tdata  out  DATA_WIDTH  to memory controller write port.
REQ-012 m01_axis_tstrb  out  DATA_WIDTH/8;  m01_axis_tvalid, m01_axis_tlast  out  1 each.
REQ-013 m01_axis_tready  in  1  memory controller ready.
REQ-014 grant_id  out  1  0 = s01 granted or last granted, 1 = s02.
REQ-015 busy  out  1  high while a packet is granted.
REQ-016 s01_pkt_cnt, s02_pkt_cnt  out  16 each  completed packets per requester.
REQ-017 trunc_err  out  1  sticky, set on any forced release.

Function
REQ-018 FSM states IDLE, GNT_S01, GNT_S02; busy = (state != IDLE).
REQ-019 IDLE: m01_axis_tvalid=0, both s tready=0, m01 data/strb/tlast=0.
REQ-020 IDLE, only s01 tvalid -> GNT_S01 next cycle; only s02 tvalid -> GNT_S02; neither -> stay.
REQ-021 IDLE, both tvalid -> grant requester not served last (round-robin); after reset s01 wins first tie.
REQ-022 GNT_Sx: m01 data/strb/tlast/tvalid combinationally follow Sx; Sx tready = m01_axis_tready; other requester tready=0.
REQ-023 Beat accepted when granted tvalid and m01_axis_tready both high; beat counter (16-bit) increments per accepted beat, clears on entry to IDLE.
REQ-024 Packet ends on accepted beat with tlast=1 -> IDLE next cycle, priority pointer records Sx, Sx pkt_cnt += 1 (wraps 0xFFFF->0x0000).
REQ-025 Accepted beat number MAX_BEATS without tlast -> m01_axis_tlast forced 1 on that beat, trunc_err set, treated as packet end per REQ-024; remaining source beats arbitrate as new packet.
REQ-026 Granted tvalid deasserting mid-packet: grant held, no timeout; no beat lost or duplicated under m01_axis_tready=0.
REQ-027 One-cycle IDLE bubble between consecutive packets, including same requester.
REQ-028 grant_id updates on entry to GNT_Sx, holds during IDLE.

Reset
REQ-029 On axis_areset: state IDLE, all tready=0, m01 outputs 0, grant_id=0, pkt_cnts=0, trunc_err=0, beat counter 0, priority favours s01; applies mid-packet, effective next edge.

Verification
REQ-030 Reset 2 cycles with s01 tvalid=1 -> all tready=0, m01_axis_tvalid=0, counts 0, trunc_err=0, busy=0.
REQ-031 s01 sends 0x55,0x22,0x24 (tlast on 0x24), tstrb=0xF, m01 tready=1 -> same order on m01, tlast only with 0x24, s01_pkt_cnt=1, IDLE one cycle after.
REQ-032 s01 and s02 both hold 2-beat packets continuously -> grants s01,s02,s01,s02; grant_id toggles 0,1,0,1; each pkt_cnt=2.
REQ-033 m01 tready=0 for 5 cycles mid s01 packet -> s01 tready=0, m01 data stable, s02 never granted, full packet delivered intact.
REQ-034 MAX_BEATS=4, s02 sends 6 beats, tlast on 6th -> m01 tlast on beats 4 and 6, trunc_err=1, s02_pkt_cnt=2.
REQ-035 Reset asserted at beat 2 of s01 packet -> next edge all outputs at reset values; new packet after release arbitrates normally.
